// File: rtl/display_7_seg_pkg.sv
// Shared segment encoding for display_7_seg: pattern type ordered {a,b,c,d,e,f,g}, 1 = lit.
// Glyph constants for digits 0-9, hex letters A-F and a blank digit.
package display_7_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/display_7_seg_lut.sv
// Combinational 4-bit to seven-segment decode. Codes 10-15 show A-F when
// DISPLAY_7_SEG_HEX_EN is defined, otherwise they decode to a blank digit.
module display_7_seg_lut
    import display_7_seg_pkg::*;
(
    input  logic [3:0] i_binary,
    output seg_t       o_pattern
);

    always_comb begin
        // NOTE: the default branch also catches X/Z codes, so no latch is inferred and the digit blanks.
        o_pattern = SEG_BLANK;
        case (i_binary)
            4'd0:    o_pattern = SEG_0;
            4'd1:    o_pattern = SEG_1;
            4'd2:    o_pattern = SEG_2;
            4'd3:    o_pattern = SEG_3;
            4'd4:    o_pattern = SEG_4;
            4'd5:    o_pattern = SEG_5;
            4'd6:    o_pattern = SEG_6;
            4'd7:    o_pattern = SEG_7;
            4'd8:    o_pattern = SEG_8;
            4'd9:    o_pattern = SEG_9;
`ifdef DISPLAY_7_SEG_HEX_EN
            4'd10:   o_pattern = SEG_A;
            4'd11:   o_pattern = SEG_B;
            4'd12:   o_pattern = SEG_C;
            4'd13:   o_pattern = SEG_D;
            4'd14:   o_pattern = SEG_E;
            4'd15:   o_pattern = SEG_F;
`else
            4'd10, 4'd11, 4'd12,
            4'd13, 4'd14, 4'd15: o_pattern = SEG_BLANK;
`endif
            default: o_pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_7_seg.sv
// Registered binary-to-seven-segment decoder: one clock of latency, glitch-free outputs.
// Build option DISPLAY_7_SEG_HEX_EN enables A-F glyphs for codes 10-15.
module display_7_seg
    import display_7_seg_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_binary,
    output logic       o_Seg_a,
    output logic       o_Seg_b,
    output logic       o_Seg_c,
    output logic       o_Seg_d,
    output logic       o_Seg_e,
    output logic       o_Seg_f,
    output logic       o_Seg_g
);

    seg_t pattern_d;
    seg_t pattern_q;

    display_7_seg_lut u_lut (
        .i_binary  (i_binary),
        .o_pattern (pattern_d)
    );

    always_ff @(posedge i_Clk) begin
        // NOTE: non-blocking assignment keeps all seven segments updating together on the same edge.
        if (i_Reset) begin
            pattern_q <= SEG_BLANK;
        end else begin
            pattern_q <= pattern_d;
        end
    end

    assign {o_Seg_a, o_Seg_b, o_Seg_c, o_Seg_d, o_Seg_e, o_Seg_f, o_Seg_g} = pattern_q;

endmodule

// File: tb/tb_display_7_seg.sv
// Self-checking bench for display_7_seg: directed steps, expected patterns queued at drive
// time and popped one edge later; honours DISPLAY_7_SEG_HEX_EN for codes 10-15.
module tb_display_7_seg;

    logic       clk;
    logic       rst;
    logic [3:0] bin;
    logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

    logic [6:0] exp_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    display_7_seg dut (
        .i_Clk    (clk),
        .i_Reset  (rst),
        .i_binary (bin),
        .o_Seg_a  (seg_a),
        .o_Seg_b  (seg_b),
        .o_Seg_c  (seg_c),
        .o_Seg_d  (seg_d),
        .o_Seg_e  (seg_e),
        .o_Seg_f  (seg_f),
        .o_Seg_g  (seg_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] model(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
`ifdef DISPLAY_7_SEG_HEX_EN
            4'd10: return 7'b1110111;
            4'd11: return 7'b0011111;
            4'd12: return 7'b1001110;
            4'd13: return 7'b0111101;
            4'd14: return 7'b1001111;
            4'd15: return 7'b1000111;
`endif
            default: return 7'b0000000;
        endcase
    endfunction

    // Drive one cycle of stimulus on the falling edge, then check just after the rising edge.
    task automatic step(input logic r, input logic [3:0] v, input string tag);
        logic [6:0] expected;
        logic [6:0] observed;
        @(negedge clk);
        rst = r;
        bin = v;
        exp_q.push_back(r ? 7'b0000000 : model(v));
        @(posedge clk);
        #1;
        observed = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
        expected = exp_q.pop_front();
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        bin = 4'd8;

        step(1'b1, 4'd8, "reset_hold_0");
        step(1'b1, 4'd8, "reset_hold_1");
        step(1'b1, 4'd14, "reset_ignores_input");
        step(1'b0, 4'd8, "release_8");

        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'(i), $sformatf("sweep_%0d", i));
        end

        step(1'b0, 4'd1, "lat_1");
        step(1'b0, 4'd7, "lat_7");
        step(1'b0, 4'd1, "lat_1_again");

        step(1'b0, 4'd14, "code_14");
        step(1'b0, 4'd15, "code_15");
        step(1'b0, 4'd11, "code_11");
        step(1'b0, 4'd10, "code_10");
        step(1'b0, 4'd12, "code_12");
        step(1'b0, 4'd13, "code_13");
        step(1'b0, 4'd3, "after_hex_3");

        step(1'b0, 4'd5, "steady_5_a");
        step(1'b0, 4'd5, "steady_5_b");
        step(1'b1, 4'd5, "midrun_reset");
        step(1'b0, 4'd5, "midrun_recover");
        step(1'b0, 4'd6, "final_6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
